// File: rtl/enigma_pkg.sv
// Shared types, rotor notch positions and the letter test for the reverse-enigma datapath.
// No logic; latency and backpressure do not apply.
package enigma_pkg;

    localparam int LETTERS = 26;

    typedef logic [4:0] letter_t;

    // Carry positions of the historical rotors I..V (Q, E, V, J, Z).
    localparam letter_t NOTCH_I   = 5'd16;
    localparam letter_t NOTCH_II  = 5'd4;
    localparam letter_t NOTCH_III = 5'd21;
    localparam letter_t NOTCH_IV  = 5'd9;
    localparam letter_t NOTCH_V   = 5'd25;

    function automatic logic is_letter(input letter_t c);
        return c < 5'(LETTERS);
    endfunction

endpackage

// File: rtl/mod26_inc.sv
// Conditional modulo-26 increment of one rotor position; purely combinational.
// Zero latency, no handshake; the enable selects step or hold.
module mod26_inc
    import enigma_pkg::*;
(
    input  letter_t inc_in,
    input  logic    inc_en,
    output letter_t inc_out
);

    always_comb begin
        inc_out = inc_in;
        if (inc_en) begin
            inc_out = (inc_in >= 5'(LETTERS - 1)) ? '0 : inc_in + 5'd1;
        end
    end

endmodule

// File: rtl/enigma_rotor_stepper.sv
// Accepts one character per handshake and steps r1/r2/r3 with odometer carry and middle-rotor double-step.
// One-cycle latency into a single-entry output register; in_ready drops while that register is held or a load is in progress.
module enigma_rotor_stepper
    import enigma_pkg::*;
#(
    parameter letter_t R1_NOTCH = NOTCH_I,
    parameter letter_t R2_NOTCH = NOTCH_II,
    parameter int      CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [4:0]       load_r1,
    input  logic [4:0]       load_r2,
    input  logic [4:0]       load_r3,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       char_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       data_out,
    output logic             passthru,
    output logic [4:0]       r1_position,
    output logic [4:0]       r2_position,
    output logic [4:0]       r3_position,
    output logic             load_err,
    output logic [CNT_W-1:0] char_count
);

    logic             out_valid_q, out_valid_d;
    letter_t          data_q, data_d;
    logic             passthru_q, passthru_d;
    letter_t          r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
    logic             load_err_q, load_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic    accept, step, c1, ds;
    letter_t r1_step, r2_step, r3_step;

    assign in_ready = rst_n && !load_en && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign step     = accept && is_letter(char_in);

    // Carry decisions look at pre-step positions, which is what produces the double-step.
    assign c1 = (r1_q == R1_NOTCH);
    assign ds = (r2_q == R2_NOTCH);

    mod26_inc u_r1_inc (.inc_in(r1_q), .inc_en(step),              .inc_out(r1_step));
    mod26_inc u_r2_inc (.inc_in(r2_q), .inc_en(step && (c1 || ds)), .inc_out(r2_step));
    mod26_inc u_r3_inc (.inc_in(r3_q), .inc_en(step && ds),        .inc_out(r3_step));

    always_comb begin
        r1_d       = r1_step;
        r2_d       = r2_step;
        r3_d       = r3_step;
        load_err_d = load_err_q;
        cnt_d      = cnt_q + CNT_W'(step);
        if (load_en) begin
            // Out-of-range load values become 0 so positions never leave 0..25.
            r1_d       = is_letter(load_r1) ? load_r1 : '0;
            r2_d       = is_letter(load_r2) ? load_r2 : '0;
            r3_d       = is_letter(load_r3) ? load_r3 : '0;
            load_err_d = !is_letter(load_r1) || !is_letter(load_r2) || !is_letter(load_r3);
            cnt_d      = '0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        data_d      = data_q;
        passthru_d  = passthru_q;
        if (accept) begin
            out_valid_d = 1'b1;
            data_d      = char_in;
            passthru_d  = !is_letter(char_in);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            passthru_q  <= 1'b0;
            r1_q        <= '0;
            r2_q        <= '0;
            r3_q        <= '0;
            load_err_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            passthru_q  <= passthru_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            r3_q        <= r3_d;
            load_err_q  <= load_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign data_out    = data_q;
    assign passthru    = passthru_q;
    assign r1_position = r1_q;
    assign r2_position = r2_q;
    assign r3_position = r3_q;
    assign load_err    = load_err_q;
    assign char_count  = cnt_q;

endmodule

// File: tb/tb_enigma_rotor_stepper.sv
// Bench for enigma_rotor_stepper: vector table, directed corner sequences, then randomized traffic vs a reference model.
module tb_enigma_rotor_stepper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en;
    logic [4:0]  load_r1, load_r2, load_r3;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  char_in;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  data_out;
    logic        passthru;
    logic [4:0]  r1_position, r2_position, r3_position;
    logic        load_err;
    logic [15:0] char_count;

    always #5 clk = ~clk;

    enigma_rotor_stepper dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en),
        .load_r1(load_r1), .load_r2(load_r2), .load_r3(load_r3),
        .in_valid(in_valid), .in_ready(in_ready), .char_in(char_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .passthru(passthru), .r1_position(r1_position), .r2_position(r2_position),
        .r3_position(r3_position), .load_err(load_err), .char_count(char_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_pos(input string nm, input int e1, input int e2, input int e3, input int ec);
        chk({nm, "_r1"}, 32'(r1_position), e1);
        chk({nm, "_r2"}, 32'(r2_position), e2);
        chk({nm, "_r3"}, 32'(r3_position), e3);
        chk({nm, "_cnt"}, 32'(char_count), ec);
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic do_load(input int a, input int b, input int c);
        load_en = 1'b1;
        load_r1 = 5'(a); load_r2 = 5'(b); load_r3 = 5'(c);
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic send_char(input int c);
        in_valid = 1'b1;
        char_in  = 5'(c);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Reference model: rotor positions as integers stepped by the odometer rules.
    int m_p1, m_p2, m_p3, m_cnt, m_ov, m_dat, m_pt, m_lerr;

    function automatic void ref_step();
        bit carry1, dbl;
        carry1 = (m_p1 == 16);
        dbl    = (m_p2 == 4);
        m_p1 = (m_p1 + 1) % 26;
        if (carry1 || dbl) m_p2 = (m_p2 + 1) % 26;
        if (dbl)           m_p3 = (m_p3 + 1) % 26;
        m_cnt = (m_cnt + 1) % 65536;
    endfunction

    typedef struct {
        int l1, l2, l3;
        int n;
        int e1, e2, e3, ec;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int last_c;
        bit exp_rdy, acc;
        int lv1, lv2, lv3, c;
        bit ld, iv, ordy;

        vecs[0] = '{25, 0, 0, 1,  0, 0, 0, 1};
        vecs[1] = '{16, 0, 0, 1, 17, 1, 0, 1};
        vecs[2] = '{16, 0, 0, 2, 18, 1, 0, 2};
        vecs[3] = '{15, 3, 0, 1, 16, 3, 0, 1};
        vecs[4] = '{15, 3, 0, 2, 17, 4, 0, 2};
        vecs[5] = '{15, 3, 0, 3, 18, 5, 1, 3};
        vecs[6] = '{25,25,25, 1,  0,25,25, 1};
        vecs[7] = '{ 3, 4,25, 1,  4, 5, 0, 1};
        vecs[8] = '{16, 4, 7, 1, 17, 5, 8, 1};

        rst_n = 1'b0; load_en = 1'b0; load_r1 = '0; load_r2 = '0; load_r3 = '0;
        in_valid = 1'b0; char_in = '0; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_passthru", 32'(passthru), 0);
        chk("rst_load_err", 32'(load_err), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk_pos("rst", 0, 0, 0, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            do_load(vecs[i].l1, vecs[i].l2, vecs[i].l3);
            last_c = 0;
            for (int k = 0; k < vecs[i].n; k++) begin
                last_c = (i * 3 + k + 1) % 26;
                send_char(last_c);
            end
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 1);
            chk($sformatf("vec%0d_data", i), 32'(data_out), last_c);
            chk($sformatf("vec%0d_passthru", i), 32'(passthru), 0);
            chk_pos($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].ec);
        end

        // Back-pressure: first char accepted, then five stalled cycles.
        do_load(0, 0, 0);
        out_ready = 1'b0;
        in_valid = 1'b1; char_in = 5'd5;
        @(negedge clk);
        char_in = 5'd6;
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_data", 32'(data_out), 5);
            chk_pos("bp", 1, 0, 0, 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_rdy", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_resume_data", 32'(data_out), 6);
        chk_pos("bp_resume", 2, 0, 0, 2);
        @(negedge clk);
        chk("bp_drain_valid", 32'(out_valid), 0);

        // Non-letter bypass, then loads with a pending output and a bad value.
        do_load(5, 6, 7);
        send_char(10);
        chk_pos("nl_pre", 6, 6, 7, 1);
        send_char(27);
        chk("nl_passthru", 32'(passthru), 1);
        chk("nl_data", 32'(data_out), 27);
        chk_pos("nl", 6, 6, 7, 1);
        out_ready = 1'b0;
        in_valid = 1'b1; char_in = 5'd3;
        do_load(1, 30, 2);
        in_valid = 1'b0;
        chk("badld_err", 32'(load_err), 1);
        chk("badld_hold_valid", 32'(out_valid), 1);
        chk("badld_hold_data", 32'(data_out), 27);
        chk_pos("badld", 1, 0, 2, 0);
        do_load(2, 2, 2);
        chk("goodld_err", 32'(load_err), 0);
        chk_pos("goodld", 2, 2, 2, 0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("goodld_drain", 32'(out_valid), 0);

        // Asynchronous reset while an output is pending.
        out_ready = 1'b0;
        send_char(9);
        chk("mid_pre_valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_data", 32'(data_out), 0);
        chk_pos("mid_rst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        m_p1 = 0; m_p2 = 0; m_p3 = 0; m_cnt = 0; m_ov = 0; m_dat = 0; m_pt = 0; m_lerr = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            ld   = ($urandom_range(0, 15) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            c    = $urandom_range(0, 31);
            lv1  = ($urandom_range(0, 7) == 0) ? $urandom_range(26, 31) : $urandom_range(0, 25);
            lv2  = ($urandom_range(0, 7) == 0) ? $urandom_range(26, 31) : $urandom_range(0, 25);
            lv3  = ($urandom_range(0, 7) == 0) ? $urandom_range(26, 31) : $urandom_range(0, 25);
            if (cyc % 97 == 5) begin
                ld = 1'b1; lv1 = 16; lv2 = 3; lv3 = $urandom_range(0, 25);
            end
            load_en = ld; in_valid = iv; out_ready = ordy; char_in = 5'(c);
            load_r1 = 5'(lv1); load_r2 = 5'(lv2); load_r3 = 5'(lv3);
            #1;
            exp_rdy = !ld && (m_ov == 0 || ordy);
            chk("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
            acc = iv && exp_rdy;
            if (ld) begin
                m_p1 = (lv1 > 25) ? 0 : lv1;
                m_p2 = (lv2 > 25) ? 0 : lv2;
                m_p3 = (lv3 > 25) ? 0 : lv3;
                m_lerr = (lv1 > 25 || lv2 > 25 || lv3 > 25);
                m_cnt = 0;
            end else if (acc && c < 26) begin
                ref_step();
            end
            if (acc) begin
                m_ov = 1; m_dat = c; m_pt = (c >= 26);
            end else if (ordy) begin
                m_ov = 0;
            end
            @(negedge clk);
            chk("rnd_out_valid", 32'(out_valid), m_ov);
            if (m_ov != 0) begin
                chk("rnd_data", 32'(data_out), m_dat);
                chk("rnd_passthru", 32'(passthru), m_pt);
            end
            chk("rnd_load_err", 32'(load_err), m_lerr);
            chk_pos("rnd", m_p1, m_p2, m_p3, m_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/enigma_rotor_stepper.md
Name: enigma_rotor_stepper

Overview:
- Upstream stage of the reverse-enigma substitution datapath.
- Accepts one 5-bit character per valid/ready handshake and advances the three rotors using Enigma odometer stepping with middle-rotor double-step.
- Presents the character with the post-step r1/r2/r3 positions that the substitution stage consumes.
- r1 is the fast rotor, r2 the middle rotor, r3 the slow rotor.

Parameters:
- R1_NOTCH, 16, r1 position at which r1 carries into r2 (rotor I, 'Q').
- R2_NOTCH, 4, r2 position at which r2 carries and double-steps (rotor II, 'E').
- CNT_W, 16, width of the processed-character counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_en  in  1  load the initial rotor positions this cycle.
- load_r1  in  5  initial r1 position.
- load_r2  in  5  initial r2 position.
- load_r3  in  5  initial r3 position.
- in_valid  in  1  char_in is valid.
- in_ready  out  1  stage can accept a character.
- char_in  in  5  0..25 = A..Z; 26..31 = non-letter.
- out_valid  out  1  data_out and positions are valid.
- out_ready  in  1  downstream accepts.
- data_out  out  5  registered copy of the accepted char_in.
- passthru  out  1  data_out is a non-letter; downstream must bypass substitution.
- r1_position  out  5  current r1 position, 0..25.
- r2_position  out  5  current r2 position, 0..25.
- r3_position  out  5  current r3 position, 0..25.
- load_err  out  1  sticky; set when a load value was greater than 25.
- char_count  out  CNT_W  letters stepped since the last reset or load.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, data_out=0, passthru=0.
  - r1/r2/r3=0, load_err=0, char_count=0.
- Handshake and registers:
  - in_ready = rst_n && !load_en && (!out_valid || out_ready).
  - Accept = in_valid && in_ready.
  - Output register is single-entry with 1-cycle latency: on accept, data_out and the positions update and out_valid=1 on the next edge.
  - out_valid falls only after a cycle with out_valid && out_ready && no new accept.
  - Outputs are held stable while out_valid && !out_ready.
- Stepping on accept of a letter (char_in 0..25), evaluated on pre-step values:
  - c1 = (r1 == R1_NOTCH).
  - ds = (r2 == R2_NOTCH).
  - r1 <= r1+1 mod 26, always.
  - r2 <= r2+1 mod 26 if c1 || ds (double-step).
  - r3 <= r3+1 mod 26 if ds.
  - Wrap: 25 -> 0; no carry from wrap itself, only from the notches.
  - char_count <= char_count+1, wrapping at 2^CNT_W.
- Non-letter accept (char_in 26..31):
  - No rotor step, char_count unchanged.
  - passthru=1 with that output; otherwise passthru=0.
- Load:
  - When load_en=1, positions load on the edge; a value greater than 25 loads 0 and sets load_err.
  - char_count clears.
  - load_err clears only on a load with all values 0..25, or on reset.
  - Load forces in_ready=0, so a simultaneous in_valid is not accepted.
  - A pending output is not dropped: out_valid and data_out are held; the position outputs show the loaded values from the next cycle.
- Reset mid-operation: a pending output is discarded and everything returns to reset values immediately (asynchronous).
- Positions never exceed 25 after reset or load; an implementation must not generate 26..31.

Decomposition:
- Shared package enigma_pkg:
  - LETTERS=26.
  - letter_t (5-bit).
  - Notch constants for rotors I–V.
  - is_letter() function.
- One natural sub-module, mod26_inc:
  - Combinational, in 5-bit + enable -> out 5-bit.
  - Instantiated three times for r1/r2/r3.
- The handshake/output register remains in the top.

Test Plan:
- Single step with wrap: load r1=25, r2=0, r3=0, send 'B'(1) -> one cycle later out_valid=1, data_out=1, r1=0, r2=0, r3=0, char_count=1.
- Normal carry: load r1=16, r2=0, r3=0, send two letters -> (17,1,0) then (18,1,0).
- Double-step: load r1=15, r2=3, r3=0, send three letters:
  - (16,3,0)
  - (17,4,0)
  - (18,5,1), showing r2 stepping twice in a row and r3 stepping.
- Back-pressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, positions and data_out frozen, one step only; release -> next char accepted, stepping resumes.
- Non-letter and bad load:
  - Send char 27 -> passthru=1, positions unchanged, char_count unchanged.
  - Load r2=30 -> r2=0, load_err=1.
  - Next valid load -> load_err=0.
- Reset mid-stream: assert rst_n=0 asynchronously while out_valid=1 -> out_valid, positions and char_count go to 0 before the next clock edge.
